// File: rtl/timer_pkg.sv
// timer_pkg: state type and start-value helpers shared by the BCD countdown timer
package timer_pkg;
  typedef enum logic [2:0] {IDLE, RUN, PAUSE, EXPIRED, RELOAD} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam int MAX_DIGITS = 8;
  function automatic int unsigned level_start(input int unsigned level, base, step, floor_v);
    int unsigned dec;
    dec = step * level;
    return (dec >= base || base - dec < floor_v) ? floor_v : base - dec;
  endfunction
  function automatic logic [4*MAX_DIGITS-1:0] bin2bcd(input int unsigned value, input int num_digits);
    logic [4*MAX_DIGITS-1:0] r;
    int unsigned v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < num_digits) begin
        r[4*i+:4] = 4'(v % 10);
        v = v / 10;
      end
    return r;
  endfunction
endpackage

// File: rtl/bcd_digit_down.sv
// bcd_digit_down: one loadable BCD nibble that decrements on borrow-in, wrapping 0 to 9
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_borrow,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic [3:0] o_nibble,
  output logic       o_borrow,
  output logic       o_zero
);
  logic [3:0] r_nib;
  always_ff @(posedge clk)
    if (!rst) r_nib <= '0;
    else if (i_load) r_nib <= i_load_val;
    else if (i_borrow) r_nib <= (r_nib == 4'd0) ? BCD_NINE : r_nib - 4'd1;
  assign o_nibble = r_nib;
  assign o_zero   = r_nib == 4'd0;
  assign o_borrow = i_borrow && o_zero;
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: level-seeded N-digit BCD countdown with pause, warning and optional auto-reload
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int PRESCALE    = 50000000,
  parameter int LEVEL_W     = 3,
  parameter int BASE_TIME   = 60,
  parameter int STEP_TIME   = 8,
  parameter int MIN_TIME    = 10,
  parameter int WARN_TIME   = 5,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    timerReconfig,
  input  logic                    timerEnable,
  input  logic [LEVEL_W-1:0]      gameLevel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    timeout,
  output logic                    warning,
  output logic                    running
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] WARN_BCD = DW'(bin2bcd(WARN_TIME, NUM_DIGITS));
  state_t r_state, w_state_nx;
  logic [PW-1:0] r_pre, w_pre_nx;
  logic [DW-1:0] r_reload, w_digits, w_load_val;
  logic [DW-1:0] w_start [2**LEVEL_W];
  logic [NUM_DIGITS:0] w_borrow;
  logic [NUM_DIGITS-1:0] w_zero;
  logic w_tick, w_load, w_last, w_nonzero, w_unused_borrow;
  // start values are elaboration-time constants, so no runtime divider is needed
  for (genvar l = 0; l < 2**LEVEL_W; l++) begin : g_start
    assign w_start[l] = DW'(bin2bcd(level_start(l, BASE_TIME, STEP_TIME, MIN_TIME), NUM_DIGITS));
  end
  assign w_tick          = r_state == RUN && r_pre == PRE_LAST;
  assign w_load          = timerReconfig || r_state == RELOAD;
  assign w_load_val      = timerReconfig ? w_start[gameLevel] : r_reload;
  assign w_borrow[0]     = w_tick;
  assign w_unused_borrow = w_borrow[NUM_DIGITS];
  assign w_nonzero       = ~&w_zero;
  assign w_last          = w_tick && w_digits == DW'(1);
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    bcd_digit_down u_digit (
      .clk       (clk),
      .rst       (rst),
      .i_borrow  (w_borrow[d]),
      .i_load    (w_load),
      .i_load_val(w_load_val[4*d+:4]),
      .o_nibble  (w_digits[4*d+:4]),
      .o_borrow  (w_borrow[d+1]),
      .o_zero    (w_zero[d])
    );
  end
  always_comb begin
    w_state_nx = r_state;
    w_pre_nx   = r_pre;
    if (timerReconfig) begin
      w_state_nx = IDLE;
      w_pre_nx   = '0;
    end else begin
      case (r_state)
        IDLE:    w_state_nx = (timerEnable && w_nonzero) ? RUN : IDLE;
        RUN: begin
          w_pre_nx   = w_tick ? '0 : r_pre + 1'b1;
          w_state_nx = w_last ? ((AUTO_RELOAD != 0) ? RELOAD : EXPIRED) : timerEnable ? RUN : PAUSE;
        end
        PAUSE:   w_state_nx = timerEnable ? RUN : PAUSE;
        RELOAD: begin
          w_pre_nx   = '0;
          w_state_nx = timerEnable ? RUN : PAUSE;
        end
        default: w_state_nx = r_state;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      r_state  <= IDLE;
      r_pre    <= '0;
      r_reload <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pre   <= w_pre_nx;
      if (timerReconfig) r_reload <= w_start[gameLevel];
    end
  assign digits  = w_digits;
  assign timeout = r_state == EXPIRED || r_state == RELOAD;
  assign running = r_state == RUN;
  assign warning = (r_state == RUN || r_state == PAUSE) && w_nonzero && w_digits <= WARN_BCD;
endmodule
